// File: rtl/mdio_slave.sv
// Clause 22 MDIO responder (PHY side) running in the clk domain.
// MDC and MDIO are synchronised and processed one bit per detected MDC rising edge.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | counting preamble ones, a 0 after enough preamble starts a frame
// S_ST    | second start bit, must be 1
// S_OP    | two opcode bits, 10 = read, 01 = write
// S_PHYAD | five PHY address bits, mismatch marks the frame as ignored
// S_REGAD | five register address bits, read strobe on the last one
// S_TA    | turnaround, slave drives 0 on reads, checks 1/0 on writes
// S_DATA  | sixteen data bits, shifted out (read) or in (write)
module mdio_slave #(
    parameter logic [4:0]  PHY_ADDR = 5'd1,
    parameter bit          BCAST_EN = 1'b0,
    parameter int unsigned PRE_LEN  = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mdc,
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_oe,
    output logic [4:0]  reg_addr,
    output logic        reg_rd,
    input  logic [15:0] reg_rdata,
    output logic        reg_wr,
    output logic [15:0] reg_wdata,
    output logic        busy,
    output logic        frame_err
);

    localparam logic [5:0] PRE_MAX = 6'd32;
    localparam logic [5:0] PRE_REQ = (PRE_LEN > 32) ? 6'd32 : 6'(PRE_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ST,
        S_OP,
        S_PHYAD,
        S_REGAD,
        S_TA,
        S_DATA
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  mdc_sync_q, mdc_sync_d;
    logic        mdc_prev_q, mdc_prev_d;
    logic [1:0]  mdio_sync_q, mdio_sync_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [5:0]  pre_cnt_q, pre_cnt_d;
    logic        op_q, op_d;
    logic        is_rd_q, is_rd_d;
    logic        ignore_q, ignore_d;
    logic [3:0]  addr_sr_q, addr_sr_d;
    logic [15:0] shift_q, shift_d;
    logic        mdio_o_q, mdio_o_d;
    logic        mdio_oe_q, mdio_oe_d;
    logic [4:0]  reg_addr_q, reg_addr_d;
    logic        reg_rd_q, reg_rd_d;
    logic        reg_wr_q, reg_wr_d;
    logic [15:0] reg_wdata_q, reg_wdata_d;
    logic        busy_q, busy_d;
    logic        frame_err_q, frame_err_d;

    logic        mdc_edge;
    logic        bit_in;
    logic [4:0]  addr_full;
    logic        phy_match;

    assign mdc_edge  = mdc_sync_q[1] & ~mdc_prev_q;
    assign bit_in    = mdio_sync_q[1];
    assign addr_full = {addr_sr_q, bit_in};
    assign phy_match = (addr_full == PHY_ADDR) ||
                       (BCAST_EN && !is_rd_q && (addr_full == 5'd0));

    // Next-state and output computation; everything frame-related moves only on an MDC edge.
    always_comb begin
        state_d     = state_q;
        mdc_sync_d  = {mdc_sync_q[0], mdc};
        mdc_prev_d  = mdc_sync_q[1];
        mdio_sync_d = {mdio_sync_q[0], mdio_i};
        cnt_d       = cnt_q;
        pre_cnt_d   = pre_cnt_q;
        op_d        = op_q;
        is_rd_d     = is_rd_q;
        ignore_d    = ignore_q;
        addr_sr_d   = addr_sr_q;
        shift_d     = shift_q;
        mdio_o_d    = mdio_o_q;
        mdio_oe_d   = mdio_oe_q;
        reg_addr_d  = reg_addr_q;
        reg_rd_d    = 1'b0;
        reg_wr_d    = 1'b0;
        reg_wdata_d = reg_wdata_q;
        busy_d      = busy_q;
        frame_err_d = 1'b0;

        // Register file answers in the cycle of the read strobe.
        if (reg_rd_q) begin
            shift_d = reg_rdata;
        end

        if (mdc_edge) begin
            case (state_q)
                S_IDLE: begin
                    if (bit_in) begin
                        if (pre_cnt_q != PRE_MAX) begin
                            pre_cnt_d = pre_cnt_q + 6'd1;
                        end
                    end else if (pre_cnt_q >= PRE_REQ) begin
                        state_d   = S_ST;
                        busy_d    = 1'b1;
                        pre_cnt_d = 6'd0;
                    end else begin
                        pre_cnt_d = 6'd0;
                    end
                end
                S_ST: begin
                    if (bit_in) begin
                        state_d = S_OP;
                        cnt_d   = 4'd1;
                    end else begin
                        state_d     = S_IDLE;
                        busy_d      = 1'b0;
                        frame_err_d = 1'b1;
                    end
                end
                S_OP: begin
                    if (cnt_q != 4'd0) begin
                        op_d  = bit_in;
                        cnt_d = cnt_q - 4'd1;
                    end else if ({op_q, bit_in} == 2'b10) begin
                        is_rd_d = 1'b1;
                        state_d = S_PHYAD;
                        cnt_d   = 4'd4;
                    end else if ({op_q, bit_in} == 2'b01) begin
                        is_rd_d = 1'b0;
                        state_d = S_PHYAD;
                        cnt_d   = 4'd4;
                    end else begin
                        state_d     = S_IDLE;
                        busy_d      = 1'b0;
                        frame_err_d = 1'b1;
                    end
                end
                S_PHYAD: begin
                    addr_sr_d = {addr_sr_q[2:0], bit_in};
                    if (cnt_q != 4'd0) begin
                        cnt_d = cnt_q - 4'd1;
                    end else begin
                        ignore_d = !phy_match;
                        state_d  = S_REGAD;
                        cnt_d    = 4'd4;
                    end
                end
                S_REGAD: begin
                    addr_sr_d = {addr_sr_q[2:0], bit_in};
                    if (cnt_q != 4'd0) begin
                        cnt_d = cnt_q - 4'd1;
                    end else begin
                        reg_addr_d = addr_full;
                        reg_rd_d   = is_rd_q && !ignore_q;
                        state_d    = S_TA;
                        cnt_d      = 4'd1;
                    end
                end
                S_TA: begin
                    if (cnt_q != 4'd0) begin
                        cnt_d = 4'd0;
                        if (is_rd_q) begin
                            if (!ignore_q) begin
                                mdio_oe_d = 1'b1;
                                mdio_o_d  = 1'b0;
                            end
                        end else if (!bit_in) begin
                            state_d     = S_IDLE;
                            busy_d      = 1'b0;
                            frame_err_d = 1'b1;
                        end
                    end else if (is_rd_q) begin
                        if (!ignore_q) begin
                            mdio_o_d = shift_q[15];
                        end
                        shift_d = {shift_q[14:0], 1'b0};
                        state_d = S_DATA;
                        cnt_d   = 4'd15;
                    end else if (bit_in) begin
                        state_d     = S_IDLE;
                        busy_d      = 1'b0;
                        frame_err_d = 1'b1;
                    end else begin
                        state_d = S_DATA;
                        cnt_d   = 4'd15;
                    end
                end
                S_DATA: begin
                    if (!is_rd_q && !ignore_q) begin
                        reg_wdata_d = {reg_wdata_q[14:0], bit_in};
                    end
                    if (cnt_q != 4'd0) begin
                        cnt_d = cnt_q - 4'd1;
                        if (is_rd_q) begin
                            if (!ignore_q) begin
                                mdio_o_d = shift_q[15];
                            end
                            shift_d = {shift_q[14:0], 1'b0};
                        end
                    end else begin
                        mdio_oe_d = 1'b0;
                        mdio_o_d  = 1'b1;
                        reg_wr_d  = !is_rd_q && !ignore_q;
                        state_d   = S_IDLE;
                        busy_d    = 1'b0;
                        pre_cnt_d = 6'd0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end

        // Pad is released on any abort so a broken frame never leaves the line driven.
        if (frame_err_d) begin
            mdio_oe_d = 1'b0;
            mdio_o_d  = 1'b1;
            pre_cnt_d = 6'd0;
        end
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mdc_sync_q  <= 2'b00;
            mdc_prev_q  <= 1'b0;
            mdio_sync_q <= 2'b11;
            cnt_q       <= 4'd0;
            pre_cnt_q   <= 6'd0;
            op_q        <= 1'b0;
            is_rd_q     <= 1'b0;
            ignore_q    <= 1'b0;
            addr_sr_q   <= 4'd0;
            shift_q     <= 16'd0;
            mdio_o_q    <= 1'b1;
            mdio_oe_q   <= 1'b0;
            reg_addr_q  <= 5'd0;
            reg_rd_q    <= 1'b0;
            reg_wr_q    <= 1'b0;
            reg_wdata_q <= 16'd0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mdc_sync_q  <= mdc_sync_d;
            mdc_prev_q  <= mdc_prev_d;
            mdio_sync_q <= mdio_sync_d;
            cnt_q       <= cnt_d;
            pre_cnt_q   <= pre_cnt_d;
            op_q        <= op_d;
            is_rd_q     <= is_rd_d;
            ignore_q    <= ignore_d;
            addr_sr_q   <= addr_sr_d;
            shift_q     <= shift_d;
            mdio_o_q    <= mdio_o_d;
            mdio_oe_q   <= mdio_oe_d;
            reg_addr_q  <= reg_addr_d;
            reg_rd_q    <= reg_rd_d;
            reg_wr_q    <= reg_wr_d;
            reg_wdata_q <= reg_wdata_d;
            busy_q      <= busy_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign mdio_o    = mdio_o_q;
    assign mdio_oe   = mdio_oe_q;
    assign reg_addr  = reg_addr_q;
    assign reg_rd    = reg_rd_q;
    assign reg_wr    = reg_wr_q;
    assign reg_wdata = reg_wdata_q;
    assign busy      = busy_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_mdio_slave.sv
// Directed bench for mdio_slave. Instance 0: PHY_ADDR=1, PRE_LEN=32, no broadcast.
// Instance 1: PHY_ADDR=2, PRE_LEN=0, broadcast writes enabled. Both share the bus.
module tb_mdio_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mdc = 1'b0;
    logic        mdio_i = 1'b1;
    logic [15:0] rdata = 16'h0000;

    logic [1:0]  mdio_o, mdio_oe, reg_rd, reg_wr, busy, frame_err;
    logic [4:0]  reg_addr_a, reg_addr_b;
    logic [15:0] wdata_a, wdata_b;

    logic [1:0]  samp_o, samp_oe, samp_busy;

    int          rd_cnt [2];
    int          wr_cnt [2];
    int          err_cnt [2];
    int          busy_cnt [2];
    logic [4:0]  rd_addr [2];
    logic [4:0]  wr_addr [2];
    logic [15:0] wr_data [2];

    int          n_assert = 0;
    int          n_fail = 0;

    mdio_slave #(.PHY_ADDR(5'd1), .BCAST_EN(1'b0), .PRE_LEN(32)) dut (
        .clk(clk), .rst(rst), .mdc(mdc), .mdio_i(mdio_i),
        .mdio_o(mdio_o[0]), .mdio_oe(mdio_oe[0]), .reg_addr(reg_addr_a),
        .reg_rd(reg_rd[0]), .reg_rdata(rdata), .reg_wr(reg_wr[0]),
        .reg_wdata(wdata_a), .busy(busy[0]), .frame_err(frame_err[0])
    );

    mdio_slave #(.PHY_ADDR(5'd2), .BCAST_EN(1'b1), .PRE_LEN(0)) dut0 (
        .clk(clk), .rst(rst), .mdc(mdc), .mdio_i(mdio_i),
        .mdio_o(mdio_o[1]), .mdio_oe(mdio_oe[1]), .reg_addr(reg_addr_b),
        .reg_rd(reg_rd[1]), .reg_rdata(rdata), .reg_wr(reg_wr[1]),
        .reg_wdata(wdata_b), .busy(busy[1]), .frame_err(frame_err[1])
    );

    // clk posedges at 5, 15, 25 ...; the bench moves mdc only on multiples of 10
    always #5 clk = ~clk;

    // Strobe monitor
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reg_rd[i])    rd_cnt[i]   <= rd_cnt[i] + 1;
            if (reg_wr[i])    wr_cnt[i]   <= wr_cnt[i] + 1;
            if (frame_err[i]) err_cnt[i]  <= err_cnt[i] + 1;
            if (busy[i])      busy_cnt[i] <= busy_cnt[i] + 1;
        end
        if (reg_rd[0]) rd_addr[0] <= reg_addr_a;
        if (reg_rd[1]) rd_addr[1] <= reg_addr_b;
        if (reg_wr[0]) begin
            wr_addr[0] <= reg_addr_a;
            wr_data[0] <= wdata_a;
        end
        if (reg_wr[1]) begin
            wr_addr[1] <= reg_addr_b;
            wr_data[1] <= wdata_b;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One MDC period; pad outputs are sampled just before the rising edge, as a master would.
    task automatic mdc_cycle(input logic b);
        mdio_i = b;
        #40;
        samp_o    = mdio_o;
        samp_oe   = mdio_oe;
        samp_busy = busy;
        #10 mdc = 1'b1;
        #50 mdc = 1'b0;
    endtask

    task automatic send_hdr(input int pre, input logic [1:0] op, input logic [4:0] phy,
                            input logic [4:0] ra);
        logic [13:0] v;
        v = {2'b01, op, phy, ra};
        repeat (pre) mdc_cycle(1'b1);
        for (int i = 13; i >= 0; i--) mdc_cycle(v[i]);
    endtask

    task automatic read_frame(input int d, input int pre, input logic [4:0] phy,
                              input logic [4:0] ra, input logic [15:0] exp_data,
                              input logic resp);
        int rd0;
        rd0 = rd_cnt[d];
        send_hdr(pre, 2'b10, phy, ra);
        check("rd_strobe", 32'(rd_cnt[d] - rd0), 32'(resp));
        if (resp) check("rd_addr", 32'(rd_addr[d]), 32'(ra));
        // TA edge 1, with the 3-clk pin-to-output latency checked around it
        mdio_i = 1'b1;
        #50 mdc = 1'b1;
        #22 check("oe_lat_before", 32'(mdio_oe[d]), 32'd0);
        #6  check("oe_lat_after", 32'(mdio_oe[d]), 32'(resp));
        #22 mdc = 1'b0;
        mdc_cycle(1'b1);
        check("ta2_oe", 32'(samp_oe[d]), 32'(resp));
        check("ta2_o", 32'(samp_o[d]), resp ? 32'd0 : 32'd1);
        check("ta2_busy", 32'(samp_busy[d]), 32'd1);
        for (int k = 1; k <= 16; k++) begin
            mdc_cycle(1'b1);
            check("rd_bit", 32'(samp_o[d]), resp ? 32'(exp_data[16-k]) : 32'd1);
            check("rd_oe", 32'(samp_oe[d]), 32'(resp));
        end
        mdc_cycle(1'b1);
        check("rd_end_oe", 32'(samp_oe[d]), 32'd0);
        check("rd_end_o", 32'(samp_o[d]), 32'd1);
        check("rd_end_busy", 32'(samp_busy[d]), 32'd0);
        check("rd_once", 32'(rd_cnt[d] - rd0), 32'(resp));
    endtask

    task automatic write_frame(input int d, input int pre, input logic [4:0] phy,
                               input logic [4:0] ra, input logic [15:0] data,
                               input logic [1:0] ta, input logic acc, input logic err);
        int wr0, err0, rd0;
        wr0  = wr_cnt[d];
        err0 = err_cnt[d];
        rd0  = rd_cnt[d];
        send_hdr(pre, 2'b01, phy, ra);
        check("wr_busy", 32'(samp_busy[d]), 32'd1);
        mdc_cycle(ta[1]);
        mdc_cycle(ta[0]);
        if (ta == 2'b10) begin
            for (int i = 15; i >= 0; i--) begin
                mdc_cycle(data[i]);
                check("wr_oe", 32'(samp_oe[d]), 32'd0);
            end
        end
        mdc_cycle(1'b1);
        mdc_cycle(1'b1);
        check("wr_strobe", 32'(wr_cnt[d] - wr0), 32'(acc));
        if (acc) begin
            check("wr_addr", 32'(wr_addr[d]), 32'(ra));
            check("wr_data", 32'(wr_data[d]), 32'(data));
        end
        check("wr_err", 32'(err_cnt[d] - err0), 32'(err));
        check("wr_no_rd", 32'(rd_cnt[d] - rd0), 32'd0);
        check("wr_end_busy", 32'(samp_busy[d]), 32'd0);
        check("wr_end_oe", 32'(samp_oe[d]), 32'd0);
    endtask

    initial begin
        int r0, w0, e0, b0;

        #40 rst = 1'b0;
        #1;
        check("rst_mdio_o", 32'(mdio_o[0]), 32'd1);
        check("rst_mdio_oe", 32'(mdio_oe[0]), 32'd0);
        check("rst_reg_rd", 32'(reg_rd[0]), 32'd0);
        check("rst_reg_wr", 32'(reg_wr[0]), 32'd0);
        check("rst_reg_addr", 32'(reg_addr_a), 32'd0);
        check("rst_reg_wdata", 32'(wdata_a), 32'd0);
        check("rst_busy", 32'(busy[0]), 32'd0);
        check("rst_frame_err", 32'(frame_err[0]), 32'd0);
        #9;

        // PRE_LEN=0 instance accepts a frame with no preamble at all
        rdata = 16'h5A3C;
        r0 = rd_cnt[0];
        read_frame(1, 0, 5'd2, 5'd7, 16'h5A3C, 1'b1);
        check("nopre_other_rd", 32'(rd_cnt[0] - r0), 32'd0);

        // Basic read and write at PHYAD 1
        rdata = 16'hAC0C;
        read_frame(0, 32, 5'd1, 5'd5, 16'hAC0C, 1'b1);
        write_frame(0, 32, 5'd1, 5'd0, 16'h1140, 2'b10, 1'b1, 1'b0);

        // Foreign address ignored, then an immediate valid read
        read_frame(0, 32, 5'd3, 5'd5, 16'hAC0C, 1'b0);
        rdata = 16'h0F31;
        read_frame(0, 32, 5'd1, 5'd17, 16'h0F31, 1'b1);

        // 20-bit preamble is too short for PRE_LEN=32
        r0 = rd_cnt[0];
        e0 = err_cnt[0];
        b0 = busy_cnt[0];
        send_hdr(20, 2'b10, 5'd1, 5'd5);
        repeat (18) mdc_cycle(1'b1);
        check("short_pre_busy", 32'(busy_cnt[0] - b0), 32'd0);
        check("short_pre_err", 32'(err_cnt[0] - e0), 32'd0);
        check("short_pre_rd", 32'(rd_cnt[0] - r0), 32'd0);

        // Broadcast write to PHYAD 0: only the broadcast-enabled instance takes it
        w0 = wr_cnt[0];
        write_frame(1, 32, 5'd0, 5'd3, 16'hBEEF, 2'b10, 1'b1, 1'b0);
        check("bcast_off_wr", 32'(wr_cnt[0] - w0), 32'd0);

        // OP=11 is malformed
        r0 = rd_cnt[0];
        w0 = wr_cnt[0];
        e0 = err_cnt[0];
        repeat (32) mdc_cycle(1'b1);
        mdc_cycle(1'b0);
        mdc_cycle(1'b1);
        mdc_cycle(1'b1);
        mdc_cycle(1'b1);
        check("op11_busy_during", 32'(samp_busy[0]), 32'd1);
        mdc_cycle(1'b1);
        mdc_cycle(1'b1);
        check("op11_err", 32'(err_cnt[0] - e0), 32'd1);
        check("op11_busy", 32'(samp_busy[0]), 32'd0);
        check("op11_rd", 32'(rd_cnt[0] - r0), 32'd0);
        check("op11_wr", 32'(wr_cnt[0] - w0), 32'd0);

        // Write with TA=00 is malformed
        write_frame(0, 32, 5'd1, 5'd4, 16'h0000, 2'b00, 1'b0, 1'b1);

        // Reset in the middle of read data
        rdata = 16'h3C96;
        r0 = rd_cnt[0];
        w0 = wr_cnt[0];
        send_hdr(32, 2'b10, 5'd1, 5'd9);
        repeat (10) mdc_cycle(1'b1);
        check("mid_oe_driving", 32'(mdio_oe[0]), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_oe", 32'(mdio_oe[0]), 32'd0);
        check("mid_rst_o", 32'(mdio_o[0]), 32'd1);
        check("mid_rst_busy", 32'(busy[0]), 32'd0);
        rst = 1'b0;
        #4;
        check("mid_rst_rd", 32'(rd_cnt[0] - r0), 32'd1);
        check("mid_rst_wr", 32'(wr_cnt[0] - w0), 32'd0);
        read_frame(0, 32, 5'd1, 5'd9, 16'h3C96, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
